alu_pipe_hs: RTL

//  Parametrised unsigned ALU with valid/ready handshake on both sides and registered results/flags.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_seq_div.sv | 76 +++++++
 rtl/alu_pipe_hs.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and result-flag bundle for the ALU pipeline stage.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NAND = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1000;
    localparam logic [3:0] OP_XNOR = 4'b1001;
    localparam logic [3:0] OP_EQ   = 4'b1010;
    localparam logic [3:0] OP_GT   = 4'b1011;
    localparam logic [3:0] OP_LT   = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;
    localparam logic [3:0] OP_SHL  = 4'b1110;
    localparam logic [3:0] OP_ILL  = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } state_t;

    // One bit per op class plus carry/borrow and error.
    typedef struct packed {
        logic carry;
        logic arith;
        logic lgc;
        logic cmp;
        logic shf;
        logic err;
    } flags_t;

endpackage

// File: rtl/alu_seq_div.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Latency: the start cycle performs the first step; done pulses after WIDTH steps in total.
// Backpressure: none; caller must not assert start while busy.
// Ports: clk, rst (async active-high), start/dividend/divisor in; busy, done, quotient, remainder out.
module alu_seq_div #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, quo_q, dsr_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q;

    // Step operands come straight from the inputs on the start cycle so the
    // first quotient bit is produced without an extra load cycle.
    logic [WIDTH-1:0] src_rem, src_quo, src_dsr;
    logic [WIDTH:0]   shifted, trial;
    logic             fits;
    logic [WIDTH-1:0] nxt_rem, nxt_quo;

    always_comb begin
        src_rem = start ? '0       : rem_q;
        src_quo = start ? dividend : quo_q;
        src_dsr = start ? divisor  : dsr_q;
        shifted = {src_rem, src_quo[WIDTH-1]};
        trial   = shifted - {1'b0, src_dsr};
        fits    = ~trial[WIDTH];
        nxt_rem = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        nxt_quo = {src_quo[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q  <= nxt_rem;
                quo_q  <= nxt_quo;
                dsr_q  <= divisor;
                cnt_q  <= CW'(WIDTH - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q <= nxt_rem;
                quo_q <= nxt_quo;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/alu_pipe_hs.sv
// Unsigned ALU stage with valid/ready on both sides and a registered result/flag beat.
// Latency: 1 cycle for all ops except non-zero divide (WIDTH+1 cycles, ALU_DIV_EN builds only).
// Backpressure: result held stable while out_valid && !out_ready; in_ready drops until it drains.
// Ports: clk, rst (async active-high); in_valid/in_ready/in_a/in_b/in_fun;
//        out_valid/out_ready/out_data/out_hi; carry/arith/logic/cmp/shift/err flags.
// Build option: define ALU_DIV_EN to enable the iterative divider; otherwise 0011 is illegal.
module alu_pipe_hs
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_fun,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] out_hi,
    output logic             carry_flag,
    output logic             arith_flag,
    output logic             logic_flag,
    output logic             cmp_flag,
    output logic             shift_flag,
    output logic             err_flag
);

    localparam int SHW = $clog2(WIDTH);

    logic               accept;
    logic               div_start;
    logic               div_done;
    logic [WIDTH-1:0]   div_quo, div_rem;
    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] prod;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   res_data, res_hi;
    flags_t             res_flags, flags_q;

    assign accept = in_valid && in_ready;

`ifdef ALU_DIV_EN
    state_t state_q, state_d;
    logic   div_busy;

    // Zero divisor is resolved in one cycle and never enters the divider.
    assign div_start = accept && (in_fun == OP_DIV) && (in_b != '0);
    assign in_ready  = (state_q == ST_IDLE) && !div_busy && (!out_valid || out_ready);

    alu_seq_div #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (in_a),
        .divisor   (in_b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (div_start) state_d = ST_DIV;
            ST_DIV:  if (div_done)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end
`else
    assign div_start = 1'b0;
    assign div_done  = 1'b0;
    assign div_quo   = '0;
    assign div_rem   = '0;
    assign in_ready  = !out_valid || out_ready;
`endif

    always_comb begin
        sum       = {1'b0, in_a} + {1'b0, in_b};
        diff      = {1'b0, in_a} - {1'b0, in_b};
        prod      = in_a * in_b;
        shamt     = in_b[SHW-1:0];
        res_data  = '0;
        res_hi    = '0;
        res_flags = '0;
        case (in_fun)
            OP_ADD:  begin res_data = sum[WIDTH-1:0];  res_flags.carry = sum[WIDTH];  res_flags.arith = 1'b1; end
            // Borrow out of the extended subtract is exactly A<B.
            OP_SUB:  begin res_data = diff[WIDTH-1:0]; res_flags.carry = diff[WIDTH]; res_flags.arith = 1'b1; end
            OP_MUL:  begin {res_hi, res_data} = prod; res_flags.arith = 1'b1; end
`ifdef ALU_DIV_EN
            OP_DIV:  begin
                res_data        = '1;
                res_hi          = in_a;
                res_flags.arith = 1'b1;
                res_flags.err   = 1'b1;
            end
`endif
            OP_AND:  begin res_data = in_a & in_b;    res_flags.lgc = 1'b1; end
            OP_OR:   begin res_data = in_a | in_b;    res_flags.lgc = 1'b1; end
            OP_NAND: begin res_data = ~(in_a & in_b); res_flags.lgc = 1'b1; end
            OP_NOR:  begin res_data = ~(in_a | in_b); res_flags.lgc = 1'b1; end
            OP_XOR:  begin res_data = in_a ^ in_b;    res_flags.lgc = 1'b1; end
            OP_XNOR: begin res_data = ~(in_a ^ in_b); res_flags.lgc = 1'b1; end
            OP_EQ:   begin res_data = (in_a == in_b) ? WIDTH'(1) : '0; res_flags.cmp = 1'b1; end
            OP_GT:   begin res_data = (in_a >  in_b) ? WIDTH'(2) : '0; res_flags.cmp = 1'b1; end
            OP_LT:   begin res_data = (in_a <  in_b) ? WIDTH'(3) : '0; res_flags.cmp = 1'b1; end
            OP_SHR:  begin res_data = in_a >> shamt;  res_flags.shf = 1'b1; end
            OP_SHL:  begin res_data = in_a << shamt;  res_flags.shf = 1'b1; end
            default: res_flags.err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_hi    <= '0;
            flags_q   <= '0;
        end else if (div_done) begin
            out_valid     <= 1'b1;
            out_data      <= div_quo;
            out_hi        <= div_rem;
            flags_q       <= '0;
            flags_q.arith <= 1'b1;
        end else if (accept) begin
            if (div_start) begin
                // Old result was consumed this cycle; nothing valid until the divider finishes.
                out_valid <= 1'b0;
            end else begin
                out_valid <= 1'b1;
                out_data  <= res_data;
                out_hi    <= res_hi;
                flags_q   <= res_flags;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign carry_flag = flags_q.carry;
    assign arith_flag = flags_q.arith;
    assign logic_flag = flags_q.lgc;
    assign cmp_flag   = flags_q.cmp;
    assign shift_flag = flags_q.shf;
    assign err_flag   = flags_q.err;

endmodule
